// File: rtl/weight_memory_loader.sv
`default_nettype none
// ============================================================================
//  Module      : weight_memory_loader
//  Description : Write-side controller for a per-neuron weight memory. A start
//                command with a weight count fills addresses 0..len-1 in order
//                from a valid/ready stream through a registered write port.
//  Revision    : 1.0  initial release
// ============================================================================
module weight_memory_loader #(
    parameter int numWeight    = 128,
    parameter int addressWidth = 7,
    parameter int dataWidth    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [addressWidth:0]   len,
    input  logic                    abort,
    input  logic                    s_valid,
    input  logic [dataWidth-1:0]    s_data,
    output logic                    s_ready,
    output logic                    wen,
    output logic [addressWidth-1:0] wadd,
    output logic [dataWidth-1:0]    win,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [addressWidth:0] c_num_weight = (addressWidth+1)'(numWeight);

    state_t                  state_q;
    logic [addressWidth:0]   cnt_q;
    logic [addressWidth:0]   cnt_d;
    logic [addressWidth:0]   len_q;
    logic                    wen_q;
    logic [addressWidth-1:0] wadd_q;
    logic [dataWidth-1:0]    win_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic w_len_ok;
    logic w_hs;
    logic w_last;

    // A zero-length or oversized request is rejected rather than clamped.
    assign w_len_ok = (len != '0) && (len <= c_num_weight);

    // Ready only while loading; an abort masks the beat presented that cycle.
    assign s_ready = (state_q == S_LOAD) && !abort;
    assign w_hs    = s_valid && s_ready;
    assign cnt_d   = cnt_q + 1'b1;
    assign w_last  = (cnt_d == len_q);

    // Control FSM with write port, busy, done and sticky error all registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            wen_q   <= 1'b0;
            wadd_q  <= '0;
            win_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wen_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            state_q <= S_LOAD;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            len_q   <= len;
                            err_q   <= 1'b0;
                        end else begin
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else if (w_hs) begin
                        wen_q  <= 1'b1;
                        wadd_q <= cnt_q[addressWidth-1:0];
                        win_q  <= s_data;
                        cnt_q  <= cnt_d;
                        if (w_last) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wen  = wen_q;
    assign wadd = wadd_q;
    assign win  = win_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_memory_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_memory_loader
//  Description : Self-checking bench for weight_memory_loader: directed
//                scenarios plus a randomized phase against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_weight_memory_loader;

    localparam int NW = 128;
    localparam int AW = 7;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len;
    logic          abort;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          wen;
    logic [AW-1:0] wadd;
    logic [DW-1:0] win;
    logic          busy;
    logic          done;
    logic          err;

    weight_memory_loader #(
        .numWeight    (NW),
        .addressWidth (AW),
        .dataWidth    (DW)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .len     (len),
        .abort   (abort),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .wen     (wen),
        .wadd    (wadd),
        .win     (win),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: job status plus the write the memory should see.
    int       m_phase;   // 0 idle, 1 loading, 2 completing
    int       m_accepted;
    int       m_target;
    bit       m_err;
    bit       m_wen;
    int       m_wadd;
    int       m_win;

    logic [DW-1:0] dut_mem [NW];
    int n_writes = 0;
    int n_done   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_accepted = 0; m_target = 0; m_err = 0;
        m_wen = 0; m_wadd = 0; m_win = 0;
    endtask

    task automatic model_step(input bit st, input int ln, input bit ab, input bit v, input int d);
        m_wen = 0;
        if (m_phase == 0) begin
            if (st) begin
                if (ln >= 1 && ln <= NW) begin
                    m_phase = 1; m_accepted = 0; m_target = ln; m_err = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (ab) begin
                m_phase = 0; m_err = 1;
            end else if (v) begin
                m_wen = 1; m_wadd = m_accepted; m_win = d;
                m_accepted++;
                if (m_accepted == m_target) m_phase = 2;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic check_outputs();
        chk("wen",  wen,  m_wen);
        chk("wadd", wadd, m_wadd);
        chk("win",  win,  m_win);
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_phase == 2);
        chk("err",  err,  m_err);
    endtask

    // One clock: drive inputs, check ready, clock, advance model, check outputs.
    task automatic cycle(input bit st, input int ln, input bit ab, input bit v, input int d);
        start = st; len = ln[AW:0]; abort = ab; s_valid = v; s_data = d[DW-1:0];
        #1;
        chk("s_ready", s_ready, (m_phase == 1) && !ab);
        @(posedge clk);
        model_step(st, ln, ab, v, d & 32'hFF);
        #1;
        check_outputs();
        if (wen === 1'b1) begin
            dut_mem[wadd] = win;
            n_writes++;
        end
        if (done === 1'b1) n_done++;
    endtask

    task automatic idle_until_free();
        for (int i = 0; i < 4 && m_phase != 0; i++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 0; len = '0; abort = 0; s_valid = 0; s_data = '0;
        #1;
        model_reset();
        chk("rst_s_ready", s_ready, 0);
        chk("rst_wen",  wen,  0);
        chk("rst_wadd", wadd, 0);
        chk("rst_win",  win,  0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err",  err,  0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int w0, d0;
    logic [7:0] pat [4];

    initial begin
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        do_reset();

        // len=4, continuous stream
        w0 = n_writes; d0 = n_done;
        cycle(1, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, pat[i]);
        idle_until_free();
        chk("t1_writes", n_writes - w0, 4);
        chk("t1_dones",  n_done - d0, 1);
        for (int i = 0; i < 4; i++) chk("t1_mem", dut_mem[i], pat[i]);

        // full depth, valid toggling, data = address
        w0 = n_writes; d0 = n_done;
        cycle(1, NW, 0, 0, 0);
        for (int i = 0; i < 2 * NW; i++) cycle(0, 0, 0, i % 2, i / 2);
        idle_until_free();
        chk("t2_writes", n_writes - w0, NW);
        chk("t2_dones",  n_done - d0, 1);
        for (int i = 0; i < NW; i++) chk("t2_mem", dut_mem[i], i);

        // illegal lengths, then a legal one clears err
        w0 = n_writes;
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(1, NW + 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        chk("t3_nowrite", n_writes - w0, 0);
        d0 = n_done;
        cycle(1, 2, 0, 0, 0);
        cycle(0, 0, 0, 1, 8'hA5);
        cycle(0, 0, 0, 1, 8'h5A);
        idle_until_free();
        chk("t3_dones", n_done - d0, 1);

        // abort on the 4th beat
        w0 = n_writes; d0 = n_done;
        cycle(1, 8, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8'h60 + i);
        cycle(0, 0, 1, 1, 8'h63);
        cycle(0, 0, 0, 1, 8'h64);
        chk("t4_writes", n_writes - w0, 3);
        chk("t4_dones",  n_done - d0, 0);

        // reset after 5 accepted beats
        w0 = n_writes; d0 = n_done;
        cycle(1, 8, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, i);
        s_valid = 1'b1;
        do_reset();
        chk("t5_writes", n_writes - w0, 5);
        chk("t5_dones",  n_done - d0, 0);
        d0 = n_done;
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 8'hC3);
        idle_until_free();
        chk("t5_mem0",  dut_mem[0], 8'hC3);
        chk("t5_dones2", n_done - d0, 1);

        // start during LOAD and during DONE is ignored
        w0 = n_writes; d0 = n_done;
        cycle(1, 5, 0, 0, 0);
        cycle(1, 3, 0, 1, 1);
        for (int i = 2; i <= 5; i++) cycle(i == 3, 2, 0, 1, i);
        cycle(1, 2, 0, 1, 9);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
        chk("t6_writes", n_writes - w0, 5);
        chk("t6_dones",  n_done - d0, 1);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int ln;
            ln = ($urandom % 10 == 0) ? $urandom_range(0, 255) : $urandom_range(1, 16);
            cycle($urandom % 6 == 0, ln, $urandom % 40 == 0, $urandom % 3 != 0, $urandom % 256);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_memory_loader.md
# weight_memory_loader

Write-side controller for the per-neuron weight memories. Accepts a start command with a weight count, takes weights from a valid/ready stream, and drives a registered synchronous write port (wen/wadd/win) that fills memory addresses 0..len-1 in order. Sits between the host/DMA weight stream and a weight memory whose read port feeds the neuron datapath, so weights can be reloaded at runtime instead of only at elaboration.

## Interface
- numWeight, 128, number of weight locations in the target memory
- addressWidth, 7, width of memory address; numWeight <= 2**addressWidth
- dataWidth, 8, width of one weight

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  load command; sampled only in IDLE
- len  input  addressWidth+1  number of weights to load; sampled with start; legal 1..numWeight
- abort  input  1  cancel an in-progress load
- s_valid  input  1  stream beat valid
- s_data  input  dataWidth  stream weight value
- s_ready  output  1  stream ready (combinational)
- wen  output  1  memory write enable (registered)
- wadd  output  addressWidth  memory write address (registered)
- win  output  dataWidth  memory write data (registered)
- busy  output  1  high whenever state is not IDLE
- done  output  1  one-cycle pulse on successful completion
- err  output  1  sticky error flag; cleared by next accepted start

## Operation
- States: IDLE, LOAD, DONE. Internal counter cnt, width addressWidth+1.
- IDLE: s_ready=0. start=1 with 1<=len<=numWeight -> LOAD, cnt=0, latch len, err cleared. start=1 with len=0 or len>numWeight -> stay IDLE, err=1, no done, no writes.
- LOAD: s_ready = !abort. Handshake = s_valid & s_ready. On handshake: next cycle wen=1, wadd=cnt[addressWidth-1:0], win=s_data; cnt increments. Handshake with cnt==len-1 -> DONE. No handshake -> wen=0 next cycle, state/cnt hold.
- abort=1 in LOAD -> IDLE, err=1, no done; the beat presented that cycle is not accepted and not written. Writes already issued stand.
- DONE: one cycle; done=1; -> IDLE unconditionally. start in DONE is ignored.
- start and len are ignored in LOAD and DONE. abort ignored outside LOAD.
- Addresses never wrap: len is bounded by numWeight, so wadd max is numWeight-1.
- wadd/win hold their last values when wen=0.

## Timing
- Reset values: s_ready 0, wen 0, wadd 0, win 0, busy 0, done 0, err 0; state IDLE, cnt 0.
- rst asserted mid-load: all outputs return to reset values asynchronously; no further writes; memory is left partially written; no done, err stays 0.
- Start accepted at edge of cycle 0 -> LOAD from cycle 1; s_ready high from cycle 1.
- Write latency: beat accepted in cycle k -> wen/wadd/win valid in cycle k+1.
- Throughput: one weight per cycle with s_valid held high.
- Continuous stream, len=N: beats accepted cycles 1..N, wen high cycles 2..N+1, state DONE and done=1 in cycle N+1 (coincident with last write), busy high cycles 1..N+1, next start accepted at end of cycle N+2 at the earliest.
- done and err never asserted in the same cycle.

## Test plan
- Reset then start len=4, s_valid continuous with data 0x11,0x22,0x33,0x44 -> wen cycles 2..5 with wadd 0..3 and matching win; done=1 only in cycle 5; busy cycles 1..5; err=0.
- len=numWeight (128), s_valid toggling every other cycle, data=address -> 128 writes, wadd 0..127 each once in order, no wadd wrap, single done pulse.
- start len=0, then start len=129 -> err=1 each time, busy stays 0, wen never asserted; following start len=2 clears err and completes normally.
- start len=8, abort asserted together with s_valid on 4th beat -> exactly 3 writes (wadd 0..2), s_ready=0 that cycle, err=1, no done, back to IDLE next cycle.
- start len=8, assert rst after 5 accepted beats -> wen, busy, s_ready drop immediately; no done; after release a start len=1 writes wadd 0 and pulses done.
- start re-asserted during LOAD with different len, and in the DONE cycle -> ignored: original len write count unchanged, no second load begins.
